ps2_key_decoder: RTL and testbench

Receives raw PS/2 keyboard clock/data lines, filters and synchronises them, and deframes 11-bit device-to-host frames. It folds the E0 (extended) and F0 (break) prefix bytes into one decoded key event per keystroke. It sits directly upstream of the game model, which consumes one-cycle key events and does no PS/2 bit handling of its own.

---
 rtl/ps2_key_decoder.sv | 169 ++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronises and glitch-filters the PS/2 lines, deframes
// 11-bit device-to-host frames and folds E0/F0 prefixes into one key event per keystroke.
module ps2_key_decoder #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_release,
  output logic       frame_err
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StRecv, StCheck} state_e;

  logic [1:0]            ps2c_sync_q, ps2d_sync_q;
  logic [FILTER_LEN-1:0] filt_q, filt_d;
  logic                  fclk_q, fclk_d;
  logic                  sample;
  state_e                state_q, state_d;
  logic [3:0]            bits_q, bits_d;
  logic [10:0]           frame_q, frame_d;
  logic [TmoW-1:0]       tmo_q, tmo_d;
  logic                  timeout;
  logic                  ext_q, ext_d, brk_q, brk_d;
  logic                  valid_q, valid_d, err_q, err_d;
  logic [7:0]            code_q, code_d;
  logic                  kext_q, kext_d, krel_q, krel_d;
  logic [7:0]            frame_byte;
  logic                  frame_ok;

  // Two-flop synchronisers; reset to the idle-high line level
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ps2c_sync_q <= 2'b11;
      ps2d_sync_q <= 2'b11;
    end else begin
      ps2c_sync_q <= {ps2c_sync_q[0], ps2c};
      ps2d_sync_q <= {ps2d_sync_q[0], ps2d};
    end
  end

  // Glitch filter: level only changes once the whole window agrees
  always_comb begin
    filt_d = {filt_q[FILTER_LEN-2:0], ps2c_sync_q[1]};
    fclk_d = fclk_q;
    if (&filt_d) begin
      fclk_d = 1'b1;
    end else if (~|filt_d) begin
      fclk_d = 1'b0;
    end
  end

  // Sample event is the cycle in which the filtered clock is about to fall
  assign sample     = fclk_q & ~fclk_d;
  assign timeout    = (state_q == StRecv) && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));
  // frame_q[0] = start, [8:1] = data LSB first, [9] = parity, [10] = stop
  assign frame_byte = frame_q[8:1];
  assign frame_ok   = ~frame_q[0] & frame_q[10] & (^frame_q[9:1]);

  // Frame FSM, timeout counter and byte assembler next-state
  always_comb begin
    state_d = state_q;
    bits_d  = bits_q;
    frame_d = frame_q;
    tmo_d   = '0;
    ext_d   = ext_q;
    brk_d   = brk_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    kext_d  = kext_q;
    krel_d  = krel_q;
    unique case (state_q)
      StIdle: begin
        if (sample) begin
          frame_d = {ps2d_sync_q[1], frame_q[10:1]};
          bits_d  = 4'd1;
          state_d = StRecv;
        end
      end
      StRecv: begin
        if (timeout) begin
          // Timeout beats a coincident sample event
          err_d   = 1'b1;
          ext_d   = 1'b0;
          brk_d   = 1'b0;
          bits_d  = 4'd0;
          state_d = StIdle;
        end else if (sample) begin
          frame_d = {ps2d_sync_q[1], frame_q[10:1]};
          bits_d  = bits_q + 4'd1;
          if (bits_q == 4'd10) begin
            state_d = StCheck;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StCheck: begin
        state_d = StIdle;
        bits_d  = 4'd0;
        if (!frame_ok) begin
          err_d = 1'b1;
          ext_d = 1'b0;
          brk_d = 1'b0;
        end else if (frame_byte == 8'hE0) begin
          ext_d = 1'b1;
        end else if (frame_byte == 8'hF0) begin
          brk_d = 1'b1;
        end else begin
          valid_d = 1'b1;
          code_d  = frame_byte;
          kext_d  = ext_q;
          krel_d  = brk_q;
          ext_d   = 1'b0;
          brk_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      filt_q  <= '1;
      fclk_q  <= 1'b1;
      state_q <= StIdle;
      bits_q  <= 4'd0;
      frame_q <= '0;
      tmo_q   <= '0;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 8'h00;
      kext_q  <= 1'b0;
      krel_q  <= 1'b0;
    end else begin
      filt_q  <= filt_d;
      fclk_q  <= fclk_d;
      state_q <= state_d;
      bits_q  <= bits_d;
      frame_q <= frame_d;
      tmo_q   <= tmo_d;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      code_q  <= code_d;
      kext_q  <= kext_d;
      krel_q  <= krel_d;
    end
  end

  assign key_valid    = valid_q;
  assign frame_err    = err_q;
  assign key_code     = code_q;
  assign key_extended = kext_q;
  assign key_release  = krel_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed self-checking bench for ps2_key_decoder with a scaled-down PS/2 bit period.
module tb_ps2_key_decoder;

  localparam int unsigned FiltLen = 8;
  localparam int unsigned TmoCyc  = 200;
  localparam int          Half    = 40;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic       key_valid, key_extended, key_release, frame_err;
  logic [7:0] key_code;

  int n_checks = 0;
  int n_pass   = 0;
  int vld_cnt  = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  int v0, e0;

  ps2_key_decoder #(
    .FILTER_LEN    (FiltLen),
    .TIMEOUT_CYCLES(TmoCyc)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .ps2c        (ps2c),
    .ps2d        (ps2d),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_extended(key_extended),
    .key_release (key_release),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled away from the active edge
  always @(negedge clk) begin
    if (key_valid) vld_cnt++;
    if (frame_err) err_cnt++;
    if (key_valid && frame_err) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Send the first nbits of a frame; data set mid-high, then a full low half-period
  task automatic send_frame(input logic [7:0] data, input bit bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^data) ^ bad_par, data, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      wait_cyc(Half / 2);
      ps2d = f[i];
      wait_cyc(Half / 2);
      ps2c = 1'b0;
      wait_cyc(Half);
      ps2c = 1'b1;
    end
    wait_cyc(Half / 2);
    ps2d = 1'b1;
    wait_cyc(Half);
  endtask

  task automatic mark;
    @(negedge clk);
    v0 = vld_cnt;
    e0 = err_cnt;
  endtask

  initial begin
    wait_cyc(3);
    @(negedge clk);
    check("rst_valid", {31'd0, key_valid}, 32'd0);
    check("rst_err", {31'd0, frame_err}, 32'd0);
    check("rst_code", {24'd0, key_code}, 32'h00);
    check("rst_ext", {31'd0, key_extended}, 32'd0);
    check("rst_rel", {31'd0, key_release}, 32'd0);
    wait_cyc(1);
    clr = 1'b0;
    wait_cyc(20);

    // Plain make code
    mark();
    send_frame(8'h1D, 1'b0, 11);
    @(negedge clk);
    check("w_vld", vld_cnt - v0, 1);
    check("w_err", err_cnt - e0, 0);
    check("w_code", {24'd0, key_code}, 32'h1D);
    check("w_ext", {31'd0, key_extended}, 32'd0);
    check("w_rel", {31'd0, key_release}, 32'd0);

    // Break prefix
    mark();
    send_frame(8'hF0, 1'b0, 11);
    @(negedge clk);
    check("f0_novld", vld_cnt - v0, 0);
    send_frame(8'h1D, 1'b0, 11);
    @(negedge clk);
    check("brk_vld", vld_cnt - v0, 1);
    check("brk_code", {24'd0, key_code}, 32'h1D);
    check("brk_rel", {31'd0, key_release}, 32'd1);
    check("brk_ext", {31'd0, key_extended}, 32'd0);

    // Extended break, then plain repeat
    mark();
    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'hF0, 1'b0, 11);
    send_frame(8'h75, 1'b0, 11);
    @(negedge clk);
    check("ext_vld", vld_cnt - v0, 1);
    check("ext_code", {24'd0, key_code}, 32'h75);
    check("ext_ext", {31'd0, key_extended}, 32'd1);
    check("ext_rel", {31'd0, key_release}, 32'd1);
    send_frame(8'h75, 1'b0, 11);
    @(negedge clk);
    check("plain_vld", vld_cnt - v0, 2);
    check("plain_ext", {31'd0, key_extended}, 32'd0);
    check("plain_rel", {31'd0, key_release}, 32'd0);
    check("no_err", err_cnt - e0, 0);

    // Parity error, then recovery
    mark();
    send_frame(8'h29, 1'b1, 11);
    @(negedge clk);
    check("par_err", err_cnt - e0, 1);
    check("par_novld", vld_cnt - v0, 0);
    check("par_code", {24'd0, key_code}, 32'h75);
    send_frame(8'h29, 1'b0, 11);
    @(negedge clk);
    check("par_rec_code", {24'd0, key_code}, 32'h29);
    check("par_rec_vld", vld_cnt - v0, 1);

    // Short low glitch on ps2c must not start a frame
    mark();
    ps2c = 1'b0;
    wait_cyc(FiltLen - 2);
    ps2c = 1'b1;
    wait_cyc(Half);
    send_frame(8'h1C, 1'b0, 11);
    @(negedge clk);
    check("gl_code", {24'd0, key_code}, 32'h1C);
    check("gl_vld", vld_cnt - v0, 1);
    check("gl_err", err_cnt - e0, 0);

    // Frame timeout, then recovery
    mark();
    send_frame(8'h1B, 1'b0, 5);
    wait_cyc(TmoCyc + 10);
    check("tmo_err", err_cnt - e0, 1);
    check("tmo_novld", vld_cnt - v0, 0);
    send_frame(8'h1B, 1'b0, 11);
    @(negedge clk);
    check("tmo_rec_code", {24'd0, key_code}, 32'h1B);
    check("tmo_rec_err", err_cnt - e0, 1);

    // Reset mid-frame
    send_frame(8'h5A, 1'b0, 4);
    clr = 1'b1;
    wait_cyc(3);
    @(negedge clk);
    check("clr_code", {24'd0, key_code}, 32'h00);
    check("clr_vld", {31'd0, key_valid}, 32'd0);
    check("clr_err", {31'd0, frame_err}, 32'd0);
    check("clr_ext", {31'd0, key_extended}, 32'd0);
    check("clr_rel", {31'd0, key_release}, 32'd0);
    wait_cyc(1);
    clr = 1'b0;
    wait_cyc(20);
    mark();
    send_frame(8'h5A, 1'b0, 11);
    @(negedge clk);
    check("post_clr_code", {24'd0, key_code}, 32'h5A);
    check("post_clr_vld", vld_cnt - v0, 1);
    check("never_both", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
